// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// adc_capture : dual-channel ADC capture with FWFT output FIFO and an
//               optional rising-edge trigger (macro ADC_CAPTURE_TRIGGER_EN).
// Revision    : 1.0
// ============================================================================
module adc_capture #(
  parameter int NSAMP      = 1024,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] chan_a,
  input  logic [11:0] chan_b,
  input  logic [11:0] trig_level,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] C_LAST = 16'(NSAMP - 1);

`ifdef ADC_CAPTURE_TRIGGER_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    FLUSH     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [23:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_ovf;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_samp;
  logic        w_last;
  logic        w_start;
  logic        w_trig;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  assign w_start = (r_state == IDLE) && start;
  assign w_last  = (r_cnt == C_LAST);

`ifdef ADC_CAPTURE_TRIGGER_EN
  logic [11:0] r_prev_a;
  logic        r_prev_vld;

  // r_prev_vld is low in the first WAIT_TRIG cycle, so a stale sample never fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_a   <= 12'd0;
      r_prev_vld <= 1'b0;
    end else begin
      r_prev_a   <= chan_a;
      r_prev_vld <= (r_state == WAIT_TRIG);
    end
  end

  assign w_trig = (r_state == WAIT_TRIG) && r_prev_vld &&
                  ($signed(r_prev_a) <  $signed(trig_level)) &&
                  ($signed(chan_a)   >= $signed(trig_level));
`else
  logic w_unused_trig;
  assign w_unused_trig = ^trig_level;
  assign w_trig        = 1'b0;
`endif

  // The crossing sample itself is written, so triggering also counts as a sample.
  assign w_samp = (r_state == CAPTURE) || w_trig;
  assign w_push = w_samp && (!w_full || w_pop);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef ADC_CAPTURE_TRIGGER_EN
          w_next = WAIT_TRIG;
`else
          w_next = CAPTURE;
`endif
        end
      end
`ifdef ADC_CAPTURE_TRIGGER_EN
      WAIT_TRIG: begin
        if (w_trig) begin
          w_next = w_last ? FLUSH : CAPTURE;
        end
      end
`endif
      CAPTURE: begin
        if (w_last) begin
          w_next = FLUSH;
        end
      end
      FLUSH: begin
        if (w_empty) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dropped samples still advance the counter so acquisition length is fixed in time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_cnt <= 16'd0;
      r_ovf <= 1'b0;
    end else if (w_samp) begin
      r_cnt <= r_cnt + 16'd1;
      if (!w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {chan_a, chan_b};
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 24'd0 : r_mem[r_rptr[AW-1:0]];
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FLUSH) && w_empty;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// tb_adc_capture : randomized bench for adc_capture with a queue-based model.
// Revision       : 1.0
// ============================================================================
module tb_adc_capture;

  localparam int NSAMP      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef ADC_CAPTURE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] chan_a = 12'd0;
  logic [11:0] chan_b = 12'd0;
  logic [11:0] trig_level = 12'd0;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        overflow;

  adc_capture #(.NSAMP(NSAMP), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan_a(chan_a), .chan_b(chan_b),
    .trig_level(trig_level), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit run_chk = 1'b0;
  logic [23:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an acquisition is "idle", "armed", "taking samples" or
  // "draining"; the FIFO is a bounded queue.
  localparam int P_IDLE = 0, P_ARMED = 1, P_TAKE = 2, P_DRAIN = 3;
  int          phase = P_IDLE;
  int          taken = 0;
  int          armed_cycles = 0;
  int          prev_a = 0;
  bit          m_ovf = 1'b0;
  logic [23:0] mq[$];

  always @(posedge clk) begin
    int  a_now;
    int  thr;
    bit  was_empty;
    bit  take;
    a_now     = int'($signed(chan_a));
    thr       = int'($signed(trig_level));
    was_empty = (mq.size() == 0);
    take      = 1'b0;
    if (!rst_n) begin
      mq.delete();
      phase = P_IDLE;
      taken = 0;
      m_ovf = 1'b0;
    end else begin
      if (phase == P_IDLE && start) begin
        taken = 0;
        m_ovf = 1'b0;
        armed_cycles = 0;
        phase = TRIG ? P_ARMED : P_TAKE;
      end else if (phase == P_ARMED) begin
        if (armed_cycles > 0 && prev_a < thr && a_now >= thr) take = 1'b1;
        armed_cycles++;
      end else if (phase == P_TAKE) begin
        take = 1'b1;
      end else if (phase == P_DRAIN && was_empty) begin
        phase = P_IDLE;
      end
      if (!was_empty && out_ready) void'(mq.pop_front());
      if (take) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back({chan_a, chan_b});
        else m_ovf = 1'b1;
        taken++;
        phase = (taken == NSAMP) ? P_DRAIN : P_TAKE;
      end
    end
    prev_a = a_now;
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("busy", 32'(busy), 32'(phase != P_IDLE));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("done", 32'(done), 32'(phase == P_DRAIN && mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    end
    if (done) done_cnt++;
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic rand_data();
    chan_a = 12'($urandom);
    chan_b = 12'($urandom);
  endtask

  task automatic wait_done(input int base, input int budget, input bit poke_start);
    int i;
    for (i = 0; i < budget; i++) begin
      rand_data();
      cyc();
      if (done_cnt > base) break;
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    chk("done_within_budget", 32'(i < budget), 32'd1);
  endtask

  initial begin
    int          base;
    logic [23:0] exp_s[$];
    logic [23:0] e;
    rst_n = 1'b0;
    repeat (3) cyc();
    run_chk = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    cyc();

`ifdef ADC_CAPTURE_TRIGGER_EN
    // Ramp 90,95,100,105 against threshold 100: 100 is the first captured sample.
    trig_level = 12'd100;
    out_ready = 1'b1;
    got.delete();
    base = done_cnt;
    start_pulse();
    foreach (exp_s[i]) exp_s.delete(i);
    for (int k = 0; k < 4; k++) begin
      chan_a = 12'(90 + 5 * k);
      cyc();
    end
    for (int k = 0; k < NSAMP - 2; k++) begin
      rand_data();
      cyc();
    end
    wait_done(base, 200, 1'b0);
    chk("trig_count", 32'(got.size()), 32'(NSAMP));
    if (got.size() > 1) begin
      e = got[0];
      chk("trig_first_a", 32'(e[23:12]), 32'd100);
      e = got[1];
      chk("trig_second_a", 32'(e[23:12]), 32'd105);
    end
`else
    // Ramp 0..NSAMP-1 with a free-flowing consumer.
    out_ready = 1'b1;
    got.delete();
    base = done_cnt;
    start_pulse();
    for (int k = 0; k < NSAMP; k++) begin
      chan_a = 12'(k);
      chan_b = 12'($urandom);
      cyc();
    end
    wait_done(base, 200, 1'b0);
    chk("ramp_count", 32'(got.size()), 32'(NSAMP));
    for (int k = 0; k < got.size(); k++) begin
      e = got[k];
      chk("ramp_a", 32'(e[23:12]), 32'(k));
    end
    chk("ramp_done_once", 32'(done_cnt - base), 32'd1);
    chk("ramp_ovf", 32'(overflow), 32'd0);

    // Stalled consumer: only the first FIFO_DEPTH samples survive.
    out_ready = 1'b0;
    got.delete();
    exp_s.delete();
    base = done_cnt;
    start_pulse();
    for (int k = 0; k < NSAMP; k++) begin
      rand_data();
      if (k < FIFO_DEPTH) exp_s.push_back({chan_a, chan_b});
      cyc();
    end
    chk("stall_ovf", 32'(overflow), 32'd1);
    repeat (5) cyc();
    chk("stall_no_done", 32'(done_cnt - base), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_done(base, 200, 1'b0);
    chk("stall_count", 32'(got.size()), 32'(FIFO_DEPTH));
    for (int k = 0; k < got.size() && k < exp_s.size(); k++)
      chk("stall_data", 32'(got[k]), 32'(exp_s[k]));

    // FIFO full but draining: every sample must be accepted.
    out_ready = 1'b0;
    got.delete();
    exp_s.delete();
    base = done_cnt;
    start_pulse();
    for (int k = 0; k < NSAMP; k++) begin
      rand_data();
      out_ready = (k >= FIFO_DEPTH);
      exp_s.push_back({chan_a, chan_b});
      cyc();
    end
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    wait_done(base, 200, 1'b0);
    chk("full_pop_count", 32'(got.size()), 32'(NSAMP));
    for (int k = 0; k < got.size(); k++)
      chk("full_pop_data", 32'(got[k]), 32'(exp_s[k]));

    // Reset mid-capture drops everything without a done pulse.
    base = done_cnt;
    start_pulse();
    for (int k = 0; k < 5; k++) begin
      rand_data();
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    repeat (3) cyc();
    chk("midrst_no_done", 32'(done_cnt - base), 32'd0);
    got.delete();
    start_pulse();
    wait_done(base, 200, 1'b0);
    chk("midrst_next_count", 32'(got.size()), 32'(NSAMP));

    // start during CAPTURE and FLUSH is ignored.
    got.delete();
    base = done_cnt;
    start_pulse();
    for (int k = 0; k < NSAMP; k++) begin
      rand_data();
      start = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    out_ready = 1'b1;
    wait_done(base, 200, 1'b1);
    chk("start_ignored_done", 32'(done_cnt - base), 32'd1);
    chk("start_ignored_total", 32'(got.size() + (overflow ? 0 : 0)) <= 32'(NSAMP) ? 32'd1 : 32'd0, 32'd1);
`endif

    // Randomized traffic; the model compare covers every cycle.
    for (int acq = 0; acq < 8; acq++) begin
      trig_level = 12'($urandom);
      start_pulse();
      for (int k = 0; k < 120; k++) begin
        rand_data();
        out_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        if (acq == 3 && k == 40) rst_n = 1'b0;
        else rst_n = 1'b1;
        cyc();
      end
      start = 1'b0;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 200 && busy; k++) begin
        rand_data();
        cyc();
      end
      chk("rand_idle_after_drain", 32'(busy || out_valid), 32'd0);
    end

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter NSAMP, default 1024: sample pairs captured per acquisition (range 1..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64: output FIFO entries (power of 2, range 4..1024).
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: acquisition request pulse.
REQ-006 SHALL have port chan_a, input, 12 bits: signed 2s-complement ADC channel A, new value every clk.
REQ-007 SHALL have port chan_b, input, 12 bits: signed 2s-complement ADC channel B, new value every clk.
REQ-008 SHALL have port trig_level, input, 12 bits: signed trigger threshold on chan_a.
REQ-009 SHALL have port out_data, output, 24 bits: {chan_a, chan_b} at the FIFO head.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the entry.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when an acquisition completes.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped.

Function
REQ-015 SHALL implement states IDLE, WAIT_TRIG, CAPTURE and FLUSH.
REQ-016 IDLE: start=1 SHALL clear overflow and the sample counter, then enter WAIT_TRIG (trigger compiled in) or CAPTURE (trigger compiled out).
REQ-017 SHALL ignore start in every state except IDLE.
REQ-018 WAIT_TRIG: SHALL enter CAPTURE on an upward crossing, defined as registered previous chan_a < trig_level and current chan_a >= trig_level, using signed compare. The crossing sample SHALL be the first sample written.
REQ-019 The first cycle of WAIT_TRIG SHALL NOT trigger; the previous-sample register is not yet valid in that cycle.
REQ-020 CAPTURE: on each cycle SHALL push {chan_a, chan_b} and increment the counter, one sample per clk.
REQ-021 Push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 A rejected push SHALL drop the sample and set overflow. The counter SHALL still increment, so acquisition length stays fixed in time.
REQ-023 After the NSAMP-th sample, the state SHALL go to FLUSH.
REQ-024 FLUSH: when the FIFO is empty, SHALL assert done for one cycle and return to IDLE.
REQ-025 FIFO SHALL be first-word-fall-through: out_valid = not empty, and out_data = head entry.
REQ-026 Pop SHALL occur when out_valid and out_ready are both high.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Latency: a sample present at edge t with the FIFO empty SHALL appear on out_valid/out_data after edge t.
REQ-029 Sample order out SHALL equal capture order. FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force state IDLE, FIFO empty, counter 0, and all outputs low: out_valid, busy, done, overflow, out_data = 0.
REQ-031 Reset asserted mid-acquisition SHALL discard all FIFO contents and SHALL NOT pulse done.

Configuration
REQ-032 Macro ADC_CAPTURE_TRIGGER_EN defined: WAIT_TRIG and the crossing comparator SHALL be compiled in.
REQ-033 Macro ADC_CAPTURE_TRIGGER_EN undefined: WAIT_TRIG SHALL be absent, trig_level SHALL be ignored, and capture SHALL start the cycle after start.

Verification
REQ-034 Trigger off, NSAMP=8, out_ready=1, chan_a=counter 0..7 from start+1 -> 8 outputs A=0..7 in order; done pulses once; overflow=0.
REQ-035 Trigger on, trig_level=100, chan_a ramps 90,95,100,105 -> first out_data A=100; exactly NSAMP entries out.
REQ-036 NSAMP=16, FIFO_DEPTH=4, out_ready=0 during capture -> 4 entries retained, overflow=1; done only after the FIFO drains once out_ready=1.
REQ-037 FIFO full and out_ready=1 during capture -> push accepted, no overflow, continuous 1 sample/clk throughput.
REQ-038 rst_n=0 for one cycle mid-CAPTURE -> busy=0, out_valid=0, no done; next start produces a full NSAMP acquisition.
REQ-039 start pulsed during CAPTURE and FLUSH -> ignored; total outputs = NSAMP.
